// File: rtl/packet_source_pkg.sv
// Shared types and constants for the packet_source traffic generator.
// Holds the FSM state enum, lane-id width helper and LFSR constants (used only with THROTTLE_EN).
package packet_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Lane-id field width carried in the upper data bits; at least 1 bit even for a single lane.
    function automatic int lid_width(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/packet_source_if.sv
// Push-side bundle between packet_source and the FIFO/DWRR harness.
// master = packet_source, slave = harness/testbench driving control and grants.
interface packet_source_if #(
    parameter int NUM_REQS = 4,
    parameter int WIDTH    = 8,
    parameter int CNTW     = 8
);
    logic                      go;
    logic [NUM_REQS-1:0]       lane_en;
    logic [CNTW-1:0]           pkt_count;
    logic [CNTW-1:0]           magic_idx;
    logic [NUM_REQS-1:0]       gnt;
    logic [NUM_REQS-1:0]       push;
    logic [NUM_REQS*WIDTH-1:0] flat_data_out;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (
        input  go, lane_en, pkt_count, magic_idx, gnt,
        output push, flat_data_out, start, busy, done, err
    );

    modport slave (
        output go, lane_en, pkt_count, magic_idx, gnt,
        input  push, flat_data_out, start, busy, done, err
    );
endinterface

// File: rtl/packet_source_src_lane.sv
// One generator lane: sequence counter, mirrored FIFO occupancy, eligibility and data formatting.
// Latency: push is combinational from registered state, first push the cycle after clear.
// Backpressure: never pushes when mirrored occupancy == DEPTH; THROTTLE_EN adds an LFSR push gate.
module src_lane
    import packet_source_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int CNTW     = 8,
    parameter int LANE_ID  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_run,
    input  logic             i_en,
    input  logic             i_gnt,
    input  logic             i_armed,
    input  logic [CNTW-1:0]  i_pkt_count,
    input  logic [CNTW-1:0]  i_magic_idx,
    output logic             o_push,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_start,
    output logic             o_gen_done,
    output logic             o_occ_zero,
    output logic             o_underflow
);
    localparam int  LIDW     = lid_width(NUM_REQS);
    localparam int  SEQW     = WIDTH - LIDW;
    localparam int  OCCW     = $clog2(DEPTH) + 1;
    localparam bit  IS_MAGIC = (LANE_ID == 0);

    logic [CNTW-1:0]  r_seq;
    logic [OCCW-1:0]  r_occ;
    logic             w_elig;
    logic             w_push;
    logic [SEQW-1:0]  w_seq_low;

    // Uses registered occupancy only, so a same-cycle grant cannot unblock a full lane.
    assign w_elig = i_run & i_en & (r_seq < i_pkt_count) & (r_occ < OCCW'(DEPTH));

`ifdef THROTTLE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED + 16'(LANE_ID);
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign w_push = w_elig & r_lfsr[0];
`else
    assign w_push = w_elig;
`endif

    assign w_seq_low   = SEQW'(r_seq);
    assign o_push      = w_push;
    assign o_dat       = w_push ? {LIDW'(LANE_ID), w_seq_low} : '0;
    assign o_start     = IS_MAGIC & w_push & (r_seq == i_magic_idx) & i_armed;
    assign o_gen_done  = ~i_en | (r_seq >= i_pkt_count);
    assign o_occ_zero  = (r_occ == '0);
    assign o_underflow = i_gnt & (r_occ == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seq <= '0;
            r_occ <= '0;
        end else if (i_clr) begin
            r_seq <= '0;
            r_occ <= '0;
        end else begin
            if (w_push) begin
                r_seq <= r_seq + 1'b1;
            end
            // A grant on an empty lane is an error upstream; hold at zero rather than wrap.
            case ({w_push, i_gnt})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= (r_occ == '0) ? r_occ : r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/packet_source.sv
// Sequence-tagged packet generator for NUM_REQS FIFO lanes with one magic (start) packet per run.
// Latency: go sampled at t -> busy and first push at t+1; done the cycle after all occupancies hit 0.
// Backpressure: per-lane occupancy mirrored from grants; optional THROTTLE_EN LFSR gating of pushes.
module packet_source
    import packet_source_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int CNTW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    packet_source_if.master   bus
);
    state_t                    r_state;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;
    logic                      r_magic_sent;
    logic [NUM_REQS-1:0]       r_lane_en;
    logic [CNTW-1:0]           r_pkt_count;
    logic [CNTW-1:0]           r_magic_idx;

    logic                      w_clr;
    logic                      w_run;
    logic                      w_start;
    logic [NUM_REQS-1:0]       w_push;
    logic [NUM_REQS-1:0]       w_start_lane;
    logic [NUM_REQS-1:0]       w_gen_done;
    logic [NUM_REQS-1:0]       w_occ_zero;
    logic [NUM_REQS-1:0]       w_underflow;
    logic [NUM_REQS*WIDTH-1:0] w_flat;

    assign w_clr = (r_state == ST_IDLE) & bus.go;
    assign w_run = (r_state == ST_RUN);

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
        src_lane #(
            .NUM_REQS (NUM_REQS),
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .CNTW     (CNTW),
            .LANE_ID  (i)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_clr       (w_clr),
            .i_run       (w_run),
            .i_en        (r_lane_en[i]),
            .i_gnt       (bus.gnt[i]),
            .i_armed     (~r_magic_sent),
            .i_pkt_count (r_pkt_count),
            .i_magic_idx (r_magic_idx),
            .o_push      (w_push[i]),
            .o_dat       (w_flat[i*WIDTH +: WIDTH]),
            .o_start     (w_start_lane[i]),
            .o_gen_done  (w_gen_done[i]),
            .o_occ_zero  (w_occ_zero[i]),
            .o_underflow (w_underflow[i])
        );
    end

    // Only lane 0 can raise its start bit; the OR just collapses the vector.
    assign w_start = |w_start_lane;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_magic_sent <= 1'b0;
            r_lane_en    <= '0;
            r_pkt_count  <= '0;
            r_magic_idx  <= '0;
        end else begin
            if (|w_underflow) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.go) begin
                        r_state      <= ST_RUN;
                        r_busy       <= 1'b1;
                        r_magic_sent <= 1'b0;
                        r_lane_en    <= bus.lane_en;
                        r_pkt_count  <= bus.pkt_count;
                        r_magic_idx  <= bus.magic_idx;
                    end
                end
                ST_RUN: begin
                    if (w_start) begin
                        r_magic_sent <= 1'b1;
                    end
                    if (&w_gen_done) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (&w_occ_zero) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!bus.go) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.push          = w_push;
    assign bus.flat_data_out = w_flat;
    assign bus.start         = w_start;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.err           = r_err;

endmodule

// File: tb/tb_packet_source.sv
// Scoreboard bench for packet_source: expected packets queued per lane at go, popped on each push.
module tb_packet_source;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int C     = 8;
    localparam int SEQB  = W - 2;

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mph_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    packet_source_if #(.NUM_REQS(N), .WIDTH(W), .CNTW(C)) bus ();

    packet_source #(.NUM_REQS(N), .WIDTH(W), .DEPTH(DEPTH), .CNTW(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    mph_t        m_ph;
    int          m_occ  [N];
    int          m_sent [N];
    bit          m_err;
    bit          m_msent;
    int          m_cnt;
    int          m_magic;
    bit [N-1:0]  m_en;
    int          exp_q  [N][$];
    int          n_push [N];
    int          n_start;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int total_push();
        int s = 0;
        for (int i = 0; i < N; i++) s += n_push[i];
        return s;
    endfunction

    always @(negedge clk) begin : mon
        logic [N-1:0]   ep;
        logic [N-1:0]   ap;
        logic [N*W-1:0] ef;
        logic           es;
        bit             all_gen;
        bit             all_empty;
        mph_t           nx;
        int             s;
        if (!rst) begin
            chk("reset_outputs", {bus.push, bus.flat_data_out, bus.start, bus.busy, bus.done, bus.err}, '0);
            m_ph = M_IDLE; m_err = 0; m_msent = 0;
            for (int i = 0; i < N; i++) begin
                m_occ[i] = 0; m_sent[i] = 0; exp_q[i].delete();
            end
        end else begin
            for (int i = 0; i < N; i++)
                ep[i] = (m_ph == M_RUN) && m_en[i] && (m_sent[i] < m_cnt) && (m_occ[i] < DEPTH);
            ap = bus.push;
`ifdef THROTTLE_EN
            chk("push_subset", ap & ~ep, '0);
            ap = ap & ep;
`else
            chk("push", ap, ep);
            ap = ep;
`endif
            ef = '0; es = 0;
            for (int i = 0; i < N; i++) begin
                if (ap[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk("sb_underrun", 1, 0);
                    end else begin
                        s = exp_q[i].pop_front();
                        ef[i*W +: W] = W'((i << SEQB) | (s % (1 << SEQB)));
                        if (i == 0 && s == m_magic && !m_msent) es = 1;
                    end
                end
                if (bus.push[i]) n_push[i]++;
            end
            chk("data", bus.flat_data_out, ef);
            chk("start", bus.start, es);
            chk("busy", bus.busy, (m_ph == M_RUN || m_ph == M_DRAIN));
            chk("done", bus.done, (m_ph == M_DONE));
            chk("err", bus.err, m_err);
            if (bus.start) n_start++;

            all_gen = 1; all_empty = 1;
            for (int i = 0; i < N; i++) begin
                if (m_en[i] && m_sent[i] < m_cnt) all_gen = 0;
                if (m_occ[i] != 0) all_empty = 0;
            end
            nx = m_ph;
            case (m_ph)
                M_IDLE:  if (bus.go) nx = M_RUN;
                M_RUN:   if (all_gen) nx = M_DRAIN;
                M_DRAIN: if (all_empty) nx = M_DONE;
                M_DONE:  if (!bus.go) nx = M_IDLE;
                default: nx = M_IDLE;
            endcase
            for (int i = 0; i < N; i++)
                if (bus.gnt[i] && m_occ[i] == 0) m_err = 1;
            if (m_ph == M_IDLE && bus.go) begin
                m_en = bus.lane_en; m_cnt = int'(bus.pkt_count); m_magic = int'(bus.magic_idx);
                m_msent = 0;
                for (int i = 0; i < N; i++) begin
                    m_occ[i] = 0; m_sent[i] = 0; exp_q[i].delete();
                    if (m_en[i]) for (int k = 0; k < m_cnt; k++) exp_q[i].push_back(k);
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    m_sent[i] += int'(ap[i]);
                    if (ap[i] && !bus.gnt[i]) m_occ[i]++;
                    else if (!ap[i] && bus.gnt[i] && m_occ[i] > 0) m_occ[i]--;
                end
                if (es) m_msent = 1;
            end
            m_ph = nx;
        end
    end

    task automatic run_test(input logic [N-1:0] en, input int cnt, input int magic, input int gprob,
                            input int quiet, input bit full_chk, input int uf_lane, output int last_cyc);
        int cyc;
        int target;
        bit finished;
        target = $countones(en) * cnt;
        last_cyc = -1;
        for (int i = 0; i < N; i++) n_push[i] = 0;
        n_start = 0;
        @(posedge clk); #1;
        bus.lane_en = en; bus.pkt_count = C'(cnt); bus.magic_idx = C'(magic);
        bus.go = 1'b1; bus.gnt = '0;
        cyc = 0; finished = 0;
        while (!finished) begin
            @(posedge clk); #1;
            cyc++;
            if (last_cyc < 0 && total_push() == target) last_cyc = cyc - 1;
            bus.gnt = '0;
            if (m_ph == M_DONE) bus.go = 1'b0;
            else if (m_ph == M_IDLE && !bus.go) finished = 1;
            if (full_chk && cyc == quiet) begin
                chk("full_stop", n_push[0], DEPTH);
                bus.gnt[0] = 1'b1;
            end else if (full_chk && cyc == quiet + 3) begin
                chk("full_one_more", n_push[0], DEPTH + 1);
            end else if ((full_chk && cyc > quiet + 3) || (!full_chk && cyc > quiet)) begin
                for (int i = 0; i < N; i++)
                    if (m_occ[i] > 0 && $urandom_range(99) < gprob) bus.gnt[i] = 1'b1;
            end
            if (uf_lane >= 0 && cyc == 2) bus.gnt[uf_lane] = 1'b1;
            if (cyc > 3000) begin
                checks++; errors++;
                $display("FAIL timeout: run still active after %0d cycles, required done", cyc);
                bus.go = 1'b0; finished = 1;
            end
        end
        bus.gnt = '0;
        chk("start_count", n_start, (en[0] && magic < cnt) ? 1 : 0);
    endtask

    initial begin
        int lc;
        int k;
        logic [N-1:0] ren;
        int rc;
        rst = 1'b0;
        bus.go = 1'b0; bus.lane_en = '0; bus.pkt_count = '0; bus.magic_idx = '0; bus.gnt = '0;
        #1;
        chk("reset_init", {bus.push, bus.flat_data_out, bus.start, bus.busy, bus.done, bus.err}, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        run_test(4'b0001, 5, 2, 100, 8, 0, -1, lc);          // basic
        chk("basic_push_cycles", lc, 5);
        run_test(4'b0001, 10, 3, 60, 15, 1, -1, lc);         // full boundary
        run_test(4'b1111, 3, 1, 50, 0, 0, -1, lc);           // multi-lane
        chk("multi_err_clear", bus.err, 0);
        run_test(4'b0011, 4, 0, 70, 0, 0, 2, lc);            // underflow on idle lane 2
        repeat (3) @(posedge clk);
        chk("err_sticky", bus.err, 1);

        for (int r = 0; r < 6; r++) begin
            ren = N'($urandom_range(1, 15));
            rc  = $urandom_range(0, 20);
            run_test(ren, rc, $urandom_range(0, rc + 2), $urandom_range(20, 90), $urandom_range(0, 6), 0, -1, lc);
        end

        run_test(4'b0001, 100, 50, 100, 0, 0, -1, lc);       // sustained single lane
`ifdef THROTTLE_EN
        chk("throttle_window", (lc >= 150 && lc <= 250), 1);
`else
        chk("full_rate", lc, 100);
`endif

        // mid-run reset
        for (int i = 0; i < N; i++) n_push[i] = 0;
        @(posedge clk); #1;
        bus.lane_en = 4'b0001; bus.pkt_count = 8'd10; bus.magic_idx = 8'd9; bus.go = 1'b1;
        k = 0;
        while (n_push[0] < 3 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("pre_reset_pushes", n_push[0], 3);
        rst = 1'b0;
        #1;
        chk("reset_async", {bus.push, bus.flat_data_out, bus.start, bus.busy, bus.done, bus.err}, '0);
        bus.go = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_test(4'b0001, 4, 0, 80, 0, 0, -1, lc);
        chk("post_reset_err", bus.err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
